// File: rtl/ads_sample_ctrl.sv
// ADS serial ADC sample controller: CONV_N pulse, 2-flop DRDY_N sync, SPI-style shift-in of a DATA_W word.
// Latency: request -> CONV_CYC (CONV) + DRDY wait + DATA_W*SCLK_DIV (SHIFT) + 1 (DONE); all outputs registered.
// No backpressure: requests while busy are dropped and flagged on OVERRUN; optional DRDY timeout via `ADS_DRDY_TIMEOUT_EN.
module ads_sample_ctrl #(
    parameter int DATA_W      = 16,
    parameter int SCLK_DIV    = 4,
    parameter int CONV_CYC    = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK_100M,
    input  logic              CLK_RST,
    input  logic              SAMPLE_EN,
    input  logic              ADS_DRDY_N,
    input  logic              ADS_DOUT,
    output logic              ADS_CONV_N,
    output logic              ADS_CS_N,
    output logic              ADS_SCLK,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_VALID,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic              TIMEOUT_ERR
);

    localparam int SHIFT_CYC = DATA_W * SCLK_DIV;
    localparam int HALF      = SCLK_DIV / 2;
    localparam int MAX_A     = (CONV_CYC > SHIFT_CYC) ? CONV_CYC : SHIFT_CYC;
    localparam int CNT_MAX   = (TIMEOUT_CYC > MAX_A) ? TIMEOUT_CYC : MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int HALF_W    = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONV      = 3'd1,
        WAIT_DRDY = 3'd2,
        SHIFT     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [HALF_W-1:0]   hcnt, hcnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                drdy_s1, drdy_s2;
    logic                timeout_hit;

    logic                conv_n_nxt, cs_n_nxt, sclk_nxt, valid_nxt, busy_nxt, overrun_nxt;
    logic [DATA_W-1:0]   data_nxt;

`ifdef ADS_DRDY_TIMEOUT_EN
    // DRDY still not seen in the last allowed wait cycle
    assign timeout_hit = (state == WAIT_DRDY) && drdy_s2 && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // DRDY_N is asynchronous; cleared to the not-ready level on reset
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            drdy_s1 <= 1'b1;
            drdy_s2 <= 1'b1;
        end else begin
            drdy_s1 <= ADS_DRDY_N;
            drdy_s2 <= drdy_s1;
        end
    end

    // State register plus the per-state cycle counter, half-period counter and shift register
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hcnt  <= hcnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Next-state logic; the cycle counter restarts on every state change and saturates
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (SAMPLE_EN) state_nxt = CONV;
            CONV:      if (cnt == CNT_W'(CONV_CYC - 1)) state_nxt = WAIT_DRDY;
            WAIT_DRDY: begin
                if (!drdy_s2)        state_nxt = SHIFT;
                else if (timeout_hit) state_nxt = IDLE;
            end
            SHIFT:     if (cnt == CNT_W'(SHIFT_CYC - 1)) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (cnt == CNT_W'(CNT_MAX))
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + CNT_W'(1);
    end

    // Output logic computed from the next state so every output is a flop aligned with its state
    always_comb begin
        conv_n_nxt  = (state_nxt != CONV);
        cs_n_nxt    = (state_nxt != SHIFT);
        busy_nxt    = (state_nxt != IDLE);
        valid_nxt   = (state_nxt == DONE);
        overrun_nxt = OVERRUN | (SAMPLE_EN && (state != IDLE));
        sclk_nxt    = 1'b0;
        hcnt_nxt    = '0;
        // SCLK starts low on SHIFT entry and toggles each HALF cycles; forced low elsewhere
        if ((state_nxt == SHIFT) && (state == SHIFT)) begin
            if (hcnt == HALF_W'(HALF - 1)) begin
                hcnt_nxt = '0;
                sclk_nxt = ~ADS_SCLK;
            end else begin
                hcnt_nxt = hcnt + HALF_W'(1);
                sclk_nxt = ADS_SCLK;
            end
        end
        // Capture DOUT on the same edge that raises SCLK, MSB first
        shreg_nxt = shreg;
        if (sclk_nxt && !ADS_SCLK)
            shreg_nxt = {shreg[DATA_W-2:0], ADS_DOUT};
        data_nxt = (state_nxt == DONE) ? shreg : DATA_OUT;
    end

    // Registered outputs
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            ADS_CONV_N  <= 1'b1;
            ADS_CS_N    <= 1'b1;
            ADS_SCLK    <= 1'b0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            ADS_CONV_N  <= conv_n_nxt;
            ADS_CS_N    <= cs_n_nxt;
            ADS_SCLK    <= sclk_nxt;
            DATA_OUT    <= data_nxt;
            DATA_VALID  <= valid_nxt;
            BUSY        <= busy_nxt;
            OVERRUN     <= overrun_nxt;
            TIMEOUT_ERR <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_ads_sample_ctrl.sv
// Self-checking bench for ads_sample_ctrl with a behavioural ADC model and transaction-level expectations.
// Latency: expectations are derived from request, DRDY and shift timing rules, not from RTL internals.
// No backpressure: overrun requests are injected and must be dropped.
module tb_ads_sample_ctrl;

    localparam int DW  = 16;
    localparam int DIV = 4;
    localparam int CC  = 8;
    localparam int TO  = 1024;
    localparam int DW2 = 24;
    localparam int DIV2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sample_en = 1'b0, drdy_n = 1'b1, dout = 1'b0;
    logic          conv_n, cs_n, sclk, data_valid, busy, overrun, terr;
    logic [DW-1:0] data_out;

    logic           sample_en2 = 1'b0, drdy_n2 = 1'b0, dout2 = 1'b0;
    logic           conv_n2, cs_n2, sclk2, dv2, busy2, ovr2, terr2;
    logic [DW2-1:0] data_out2;

    ads_sample_ctrl #(.DATA_W(DW), .SCLK_DIV(DIV), .CONV_CYC(CC), .TIMEOUT_CYC(TO)) dut (
        .CLK_100M(clk), .CLK_RST(rst), .SAMPLE_EN(sample_en), .ADS_DRDY_N(drdy_n), .ADS_DOUT(dout),
        .ADS_CONV_N(conv_n), .ADS_CS_N(cs_n), .ADS_SCLK(sclk), .DATA_OUT(data_out),
        .DATA_VALID(data_valid), .BUSY(busy), .OVERRUN(overrun), .TIMEOUT_ERR(terr));

    ads_sample_ctrl #(.DATA_W(DW2), .SCLK_DIV(DIV2), .CONV_CYC(CC), .TIMEOUT_CYC(TO)) dut2 (
        .CLK_100M(clk), .CLK_RST(rst), .SAMPLE_EN(sample_en2), .ADS_DRDY_N(drdy_n2), .ADS_DOUT(dout2),
        .ADS_CONV_N(conv_n2), .ADS_CS_N(cs_n2), .ADS_SCLK(sclk2), .DATA_OUT(data_out2),
        .DATA_VALID(dv2), .BUSY(busy2), .OVERRUN(ovr2), .TIMEOUT_ERR(terr2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: presents the bit for the next SCLK rise, MSB first, while CS_N is low
    logic [DW-1:0]  pat1 = '0;
    logic [DW2-1:0] pat2 = '0;
    int  rises1 = 0, rises2 = 0;
    logic sp1 = 1'b0, sp2 = 1'b0;

    always @(negedge clk) begin
        if (cs_n) rises1 = 0;
        else if (sclk && !sp1) rises1++;
        sp1 = sclk;
        dout = (!cs_n && rises1 < DW) ? pat1[DW-1-rises1] : 1'b0;
        if (cs_n2) rises2 = 0;
        else if (sclk2 && !sp2) rises2++;
        sp2 = sclk2;
        dout2 = (!cs_n2 && rises2 < DW2) ? pat2[DW2-1-rises2] : 1'b0;
    end

    // Reference state: last word delivered and sticky overrun
    logic [DW-1:0] exp_data = '0;
    logic          exp_ovr  = 1'b0;

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_conv_n"},  conv_n, 1);
        check({pfx, "_cs_n"},    cs_n, 1);
        check({pfx, "_sclk"},    sclk, 0);
        check({pfx, "_data"},    data_out, 0);
        check({pfx, "_valid"},   data_valid, 0);
        check({pfx, "_busy"},    busy, 0);
        check({pfx, "_overrun"}, overrun, 0);
        check({pfx, "_terr"},    terr, 0);
    endtask

    task automatic run_txn(input logic [DW-1:0] pat, input bit early, input int dly,
                           input bit ovr_inj, input bit abort7);
        int cyc = 0, r = -1, drdy_at = -1, conv_low = 0, cs_low = 0, first_cs = -1, last_cs = -1;
        int dv_cnt = 0, dv_cyc = -1, rises = 0, tail = 0, bad_sclk = 0, last_rise = -1;
        int abort_cyc = -1, exp_first;
        bit done = 0, prev_sclk = 0;
        logic [DW-1:0] got_data = '0;
        pat1 = pat;
        drdy_n = early ? 1'b0 : 1'b1;
        if (early) repeat (4) @(negedge clk);
        @(negedge clk);
        sample_en = 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            sample_en = 1'b0;
            if (rst) begin
                rst = 1'b0;
                exp_ovr = 1'b0;
                exp_data = '0;
                check_reset_vals("abort");
                drdy_n = 1'b1;
            end
            if (!conv_n) conv_low++;
            if (conv_n && conv_low > 0 && r < 0) r = cyc;
            if (!early && r >= 0 && cyc == r + dly && abort_cyc < 0) begin
                drdy_n = 1'b0;
                drdy_at = cyc;
            end
            if (!cs_n) begin
                cs_low++;
                if (first_cs < 0) first_cs = cyc;
                last_cs = cyc;
            end
            if (sclk && cs_n) bad_sclk++;
            if (sclk && !prev_sclk) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != DIV) bad_sclk++;
                last_rise = cyc;
            end
            prev_sclk = sclk;
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
                got_data = data_out;
                if (ovr_inj) sample_en = 1'b1;
            end
            if (ovr_inj && !cs_n && cs_low == 10) sample_en = 1'b1;
            if (abort7 && rises == 7 && abort_cyc < 0) begin
                rst = 1'b1;
                abort_cyc = cyc;
            end
            if (dv_cnt > 0) tail++;
            if (tail > 5) done = 1;
            if (abort_cyc >= 0 && cyc >= abort_cyc + 80) done = 1;
        end
        drdy_n = 1'b1;
        if (!done) check("txn_budget", 0, 1);
        if (abort7) begin
            check("abort_no_valid", dv_cnt, 0);
            check("abort_idle_busy", busy, 0);
        end else begin
            exp_first = early ? r + 1 : ((drdy_at + 3 > r + 1) ? drdy_at + 3 : r + 1);
            exp_data = pat;
            exp_ovr  = exp_ovr | ovr_inj;
            check("conv_low_cycles", conv_low, CC);
            check("shift_start", first_cs, exp_first);
            check("shift_len", cs_low, DW * DIV);
            check("sclk_rises", rises, DW);
            check("sclk_shape", bad_sclk, 0);
            check("valid_count", dv_cnt, 1);
            check("valid_after_shift", dv_cyc, last_cs + 1);
            check("data_at_valid", got_data, exp_data);
            check("data_hold", data_out, exp_data);
            check("overrun", overrun, exp_ovr);
            check("busy_after", busy, 0);
        end
    endtask

    task automatic test_no_drdy();
        int cyc = 0, r = -1, terr_cnt = 0, terr_cyc = -1, busy_lo = 0, conv_low = 0;
        logic busy_at_terr = 1'b1;
        drdy_n = 1'b1;
        @(negedge clk);
        sample_en = 1'b1;
        while (cyc < 1200) begin
            @(negedge clk);
            cyc++;
            sample_en = 1'b0;
            if (!conv_n) conv_low++;
            if (conv_n && conv_low > 0 && r < 0) r = cyc;
            if (terr) begin
                terr_cnt++;
                terr_cyc = cyc;
                busy_at_terr = busy;
            end
            if (r >= 0 && !busy) busy_lo++;
        end
`ifdef ADS_DRDY_TIMEOUT_EN
        check("timeout_count", terr_cnt, 1);
        check("timeout_time", terr_cyc, r + TO);
        check("timeout_busy", busy_at_terr, 0);
        check("timeout_data", data_out, exp_data);
`else
        check("no_timeout_err", terr_cnt, 0);
        check("wait_busy_held", busy_lo, 0);
        check("wait_cs_high", cs_n, 1);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ovr  = 1'b0;
        exp_data = '0;
        check_reset_vals("post_wait_rst");
    endtask

    task automatic test_wide();
        int cyc = 0, cs_low = 0, rises = 0, dv_cnt = 0, bad = 0, last_rise = -1;
        logic prev = 1'b0;
        logic [DW2-1:0] got = '0;
        pat2 = 24'h123456;
        @(negedge clk);
        sample_en2 = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            sample_en2 = 1'b0;
            if (!cs_n2) cs_low++;
            if (sclk2 && !prev) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != DIV2) bad++;
                last_rise = cyc;
            end
            prev = sclk2;
            if (dv2) begin
                dv_cnt++;
                got = data_out2;
            end
        end
        check("w24_shift_len", cs_low, DW2 * DIV2);
        check("w24_rises", rises, DW2);
        check("w24_sclk_period", bad, 0);
        check("w24_valid_count", dv_cnt, 1);
        check("w24_data", got, 24'h123456);
        check("w24_hold", data_out2, 24'h123456);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        run_txn(16'hA5C3, 1'b0, 20, 1'b0, 1'b0);
        run_txn(16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
        run_txn(16'($urandom), 1'b0, 5, 1'b1, 1'b0);
        run_txn(16'h0F0F, 1'b0, 3, 1'b0, 1'b1);
        run_txn(16'h3C5A, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            run_txn(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)),
                    ($urandom_range(0, 3) == 0), 1'b0);
        test_no_drdy();
        run_txn(16'h8001, 1'b0, 7, 1'b0, 1'b0);
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
